vec_cat: RTL and testbench

//  Repacks a stream of padded bit-vectors into a dense, gap-free BUS_WIDTH stream.

---
 rtl/vec_cat_pkg.sv | 32 +++
 rtl/vec_cat.sv | 164 ++++++++++++++++
 tb/tb_vec_cat.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_cat_pkg.sv
// Shared defaults and derived-size helpers for the vec_cat repacker.
// Sizes are functions so each instance derives them from its own parameters.
package vec_cat_pkg;

   localparam int DEF_BUS_WIDTH    = 128;
   localparam int DEF_VECTOR_WIDTH = 920;
   localparam int DEF_VEC_ID_WIDTH = 8;

   // Bus words per padded input vector.
   function automatic int calc_wpv(input int bw, input int vw);
      return (vw + bw - 1) / bw;
   endfunction

   // Valid bits carried by the final word of each vector.
   function automatic int calc_rem(input int bw, input int vw);
      return vw - (calc_wpv(bw, vw) - 1) * bw;
   endfunction

   function automatic int calc_fill_w(input int bw);
      return $clog2(2 * bw + 1);
   endfunction

   function automatic int calc_wcnt_w(input int wpv);
      return $clog2(wpv + 1);
   endfunction

   // Bit offset within a vector, range 0..vw-1.
   function automatic int calc_off_w(input int vw);
      return $clog2(vw + 1);
   endfunction

endpackage

// File: rtl/vec_cat.sv
// Drops the per-vector padding from a word stream and emits a dense BUS_WIDTH stream,
// tagging each output word with the ID of the vector that owns its bit 0.
module vec_cat
   import vec_cat_pkg::*;
#(
   parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
   parameter int VECTOR_WIDTH = DEF_VECTOR_WIDTH,
   parameter int VEC_ID_WIDTH = DEF_VEC_ID_WIDTH
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [BUS_WIDTH-1:0]    i_Vector,
   input  logic                    i_Valid,
   input  logic                    i_Last,
   output logic                    o_Read,
   output logic [BUS_WIDTH-1:0]    o_Vector,
   output logic [VEC_ID_WIDTH-1:0] o_VecID,
   output logic                    o_Valid,
   output logic                    o_Last,
   input  logic                    i_Ready
);

   localparam int WPV    = calc_wpv(BUS_WIDTH, VECTOR_WIDTH);
   localparam int REM    = calc_rem(BUS_WIDTH, VECTOR_WIDTH);
   localparam int FILL_W = calc_fill_w(BUS_WIDTH);
   localparam int WCNT_W = calc_wcnt_w(WPV);
   localparam int OFF_W  = calc_off_w(VECTOR_WIDTH);
   localparam int AW     = 2 * BUS_WIDTH;
   localparam logic [BUS_WIDTH-1:0] REM_MASK = {BUS_WIDTH{1'b1}} >> (BUS_WIDTH - REM);

   logic [AW-1:0]           acc_q, acc_d;
   logic [FILL_W-1:0]       fill_q, fill_d;
   logic [WCNT_W-1:0]       w_q, w_d;
   logic [VEC_ID_WIDTH-1:0] acc_id_q, acc_id_d;
   logic [OFF_W-1:0]        off_q, off_d;
   logic                    flush_q, flush_d;
   logic [BUS_WIDTH-1:0]    o_vector_q, o_vector_d;
   logic [VEC_ID_WIDTH-1:0] o_vec_id_q, o_vec_id_d;
   logic                    o_valid_q, o_valid_d;
   logic                    o_last_q, o_last_d;

   logic                    rd;
   logic                    last_word;
   logic [FILL_W-1:0]       add_bits;
   logic [FILL_W-1:0]       fill_app;
   logic [AW-1:0]           acc_app;
   logic [VEC_ID_WIDTH-1:0] id_adv;
   logic [OFF_W-1:0]        off_adv;
   int                      off_sum;

   // Pop handshake: a slot must be free and no residual word may be waiting.
   assign rd        = rstn & i_Valid & (~o_valid_q | i_Ready) & ~flush_q;
   assign o_Read    = rd;
   assign o_Vector  = o_vector_q;
   assign o_VecID   = o_vec_id_q;
   assign o_Valid   = o_valid_q;
   assign o_Last    = o_last_q;

   always_comb begin
      last_word = (w_q == WCNT_W'(WPV - 1));
      add_bits  = last_word ? FILL_W'(REM) : FILL_W'(BUS_WIDTH);
      fill_app  = fill_q + add_bits;
      acc_app   = acc_q | (AW'(i_Vector & (last_word ? REM_MASK : {BUS_WIDTH{1'b1}})) << fill_q);
      // Advance bit-0 ownership by one emitted word; may cross several short vectors.
      off_sum   = int'(off_q) + BUS_WIDTH;
      id_adv    = acc_id_q + VEC_ID_WIDTH'(off_sum / VECTOR_WIDTH);
      off_adv   = OFF_W'(off_sum % VECTOR_WIDTH);

      acc_d      = acc_q;
      fill_d     = fill_q;
      w_d        = w_q;
      acc_id_d   = acc_id_q;
      off_d      = off_q;
      flush_d    = flush_q;
      o_vector_d = o_vector_q;
      o_vec_id_d = o_vec_id_q;
      o_valid_d  = o_valid_q;
      o_last_d   = o_last_q;

      if (o_valid_q && i_Ready) begin
         o_valid_d = 1'b0;
         o_last_d  = 1'b0;
      end

      if (flush_q) begin
         if (!o_valid_q || i_Ready) begin
            o_vector_d = acc_q[BUS_WIDTH-1:0];
            o_vec_id_d = acc_id_q;
            o_valid_d  = 1'b1;
            o_last_d   = 1'b1;
            acc_d      = '0;
            fill_d     = '0;
            w_d        = '0;
            acc_id_d   = '0;
            off_d      = '0;
            flush_d    = 1'b0;
         end
      end else if (rd) begin
         w_d = last_word ? '0 : w_q + 1'b1;
         if (fill_app >= FILL_W'(BUS_WIDTH)) begin
            o_vector_d = acc_app[BUS_WIDTH-1:0];
            o_vec_id_d = acc_id_q;
            o_valid_d  = 1'b1;
            acc_d      = acc_app >> BUS_WIDTH;
            fill_d     = fill_app - FILL_W'(BUS_WIDTH);
            acc_id_d   = id_adv;
            off_d      = off_adv;
            if (i_Last) begin
               if (fill_app != FILL_W'(BUS_WIDTH)) begin
                  flush_d = 1'b1;
               end else begin
                  o_last_d = 1'b1;
                  acc_d    = '0;
                  fill_d   = '0;
                  w_d      = '0;
                  acc_id_d = '0;
                  off_d    = '0;
               end
            end
         end else if (i_Last) begin
            // Residual shorter than a word: bits above fill are already zero.
            o_vector_d = acc_app[BUS_WIDTH-1:0];
            o_vec_id_d = acc_id_q;
            o_valid_d  = 1'b1;
            o_last_d   = 1'b1;
            acc_d      = '0;
            fill_d     = '0;
            w_d        = '0;
            acc_id_d   = '0;
            off_d      = '0;
         end else begin
            acc_d  = acc_app;
            fill_d = fill_app;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q      <= '0;
         fill_q     <= '0;
         w_q        <= '0;
         acc_id_q   <= '0;
         off_q      <= '0;
         flush_q    <= 1'b0;
         o_vector_q <= '0;
         o_vec_id_q <= '0;
         o_valid_q  <= 1'b0;
         o_last_q   <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         fill_q     <= fill_d;
         w_q        <= w_d;
         acc_id_q   <= acc_id_d;
         off_q      <= off_d;
         flush_q    <= flush_d;
         o_vector_q <= o_vector_d;
         o_vec_id_q <= o_vec_id_d;
         o_valid_q  <= o_valid_d;
         o_last_q   <= o_last_d;
      end
   end

endmodule

// File: tb/tb_vec_cat.sv
// Scoreboard bench for vec_cat: a bit-level reference stream is built per test and
// the dense words, IDs and last flags the DUT emits are compared against it.
module tb_vec_cat;

   localparam int BW  = 128;
   localparam int VW  = 920;
   localparam int IDW = 8;
   localparam int WPV = 8;
   localparam int REM = 24;

   logic           clk = 1'b0;
   logic           rstn;
   logic [BW-1:0]  i_Vector;
   logic           i_Valid;
   logic           i_Last;
   logic           o_Read;
   logic [BW-1:0]  o_Vector;
   logic [IDW-1:0] o_VecID;
   logic           o_Valid;
   logic           o_Last;
   logic           i_Ready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [BW-1:0]  in_q[$];
   bit             in_last_q[$];
   logic [BW-1:0]  exp_q[$];
   logic [IDW-1:0] exp_id_q[$];
   bit             exp_last_q[$];
   logic [BW-1:0]  rec_data[$];
   logic [IDW-1:0] rec_id[$];
   bit             rec_last[$];

   bit gaps     = 1'b0;
   bit rand_rdy = 1'b0;
   bit drv_done = 1'b0;

   vec_cat #(.BUS_WIDTH(BW), .VECTOR_WIDTH(VW), .VEC_ID_WIDTH(IDW)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .i_Vector (i_Vector),
      .i_Valid  (i_Valid),
      .i_Last   (i_Last),
      .o_Read   (o_Read),
      .o_Vector (o_Vector),
      .o_VecID  (o_VecID),
      .o_Valid  (o_Valid),
      .o_Last   (o_Last),
      .i_Ready  (i_Ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Ready pattern: on for 0-10 extra cycles, off for 0-5 extra cycles.
   initial begin
      bit rdy_on = 1'b1;
      int cnt    = 0;
      i_Ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!rand_rdy) begin
            i_Ready = 1'b1;
         end else begin
            if (cnt > 0) cnt--;
            else begin
               rdy_on = !rdy_on;
               cnt    = rdy_on ? $urandom_range(0, 10) : $urandom_range(0, 5);
            end
            i_Ready = rdy_on;
         end
      end
   end

   // Builds input words (with random padding) and the expected dense output.
   task automatic build_stream(input int nvec, input int trunc_words);
      bit            bits[$];
      logic [BW-1:0] word;
      int            nb, n;
      exp_q.delete(); exp_id_q.delete(); exp_last_q.delete();
      in_q.delete(); in_last_q.delete();
      for (int v = 0; v < nvec + 1; v++) begin
         for (int w = 0; w < WPV; w++) begin
            if (v == nvec && w >= trunc_words) break;
            word = {$urandom, $urandom, $urandom, $urandom};
            nb   = (v < nvec && w == WPV - 1) ? REM : BW;
            for (int b = 0; b < nb; b++) bits.push_back(word[b]);
            in_q.push_back(word);
            in_last_q.push_back(1'b0);
         end
      end
      in_last_q[in_last_q.size() - 1] = 1'b1;
      n = bits.size();
      for (int s = 0; s < n; s += BW) begin
         word = '0;
         for (int b = 0; b < BW; b++) if (s + b < n) word[b] = bits[s + b];
         exp_q.push_back(word);
         exp_id_q.push_back(IDW'((s / VW) % 256));
         exp_last_q.push_back(s + BW >= n);
      end
   endtask

   task automatic drive_words();
      logic [BW-1:0] word;
      bit            last, took;
      @(negedge clk);
      while (in_q.size() > 0) begin
         word = in_q.pop_front();
         last = in_last_q.pop_front();
         if (gaps && $urandom_range(0, 2) == 0) begin
            i_Valid  = 1'b0;
            i_Vector = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         i_Vector = word;
         i_Last   = last;
         i_Valid  = 1'b1;
         took     = 1'b0;
         for (int c = 0; c < 200 && !took; c++) begin
            #2;
            took = o_Read;
            @(negedge clk);
         end
         if (!took) begin
            chk("read_timeout", BW'(took), BW'(1));
            in_q.delete();
            in_last_q.delete();
         end
      end
      i_Valid  = 1'b0;
      i_Last   = 1'b0;
      drv_done = 1'b1;
   endtask

   task automatic monitor();
      int            idle = 0;
      bit            holding = 1'b0;
      logic [BW-1:0] held = '0;
      while ((exp_q.size() > 0 || !drv_done) && idle < 2000) begin
         @(negedge clk);
         #2;
         if (holding) begin
            chk("hold_valid", BW'(o_Valid), BW'(1));
            chk("hold_data", o_Vector, held);
            holding = 1'b0;
         end
         if (o_Valid && i_Ready) begin
            idle = 0;
            rec_data.push_back(o_Vector);
            rec_id.push_back(o_VecID);
            rec_last.push_back(o_Last);
            if (exp_q.size() == 0) begin
               chk("extra_word", BW'(1), BW'(0));
            end else begin
               chk("data", o_Vector, exp_q.pop_front());
               chk("vec_id", BW'(o_VecID), BW'(exp_id_q.pop_front()));
               chk("last", BW'(o_Last), BW'(exp_last_q.pop_front()));
            end
         end else if (o_Valid) begin
            idle    = 0;
            holding = 1'b1;
            held    = o_Vector;
            chk("read_in_stall", BW'(o_Read), BW'(0));
         end else begin
            idle++;
         end
      end
      if (exp_q.size() > 0) chk("out_timeout_left", BW'(exp_q.size()), BW'(0));
   endtask

   task automatic run_stream();
      rec_data.delete(); rec_id.delete(); rec_last.delete();
      drv_done = 1'b0;
      fork
         drive_words();
         monitor();
      join
   endtask

   initial begin
      rstn     = 1'b0;
      i_Valid  = 1'b1;
      i_Last   = 1'b0;
      i_Vector = '1;
      repeat (3) @(negedge clk);
      chk("rst_vector", o_Vector, BW'(0));
      chk("rst_vecid", BW'(o_VecID), BW'(0));
      chk("rst_valid", BW'(o_Valid), BW'(0));
      chk("rst_last", BW'(o_Last), BW'(0));
      chk("rst_read", BW'(o_Read), BW'(0));
      i_Valid = 1'b0;
      rstn    = 1'b1;

      // Two vectors, always ready.
      build_stream(2, 0);
      run_stream();
      chk("t1_nwords", BW'(rec_data.size()), BW'(15));
      if (rec_data.size() == 15) begin
         chk("t1_last14", BW'(rec_last[14]), BW'(1));
         chk("t1_pad14", rec_data[14] >> 48, BW'(0));
         chk("t2_id7", BW'(rec_id[7]), BW'(0));
         chk("t2_id8", BW'(rec_id[8]), BW'(1));
      end

      // Random backpressure.
      rand_rdy = 1'b1;
      build_stream(136, 0);
      run_stream();
      chk("t3_nwords", BW'(rec_data.size()), BW'(978));

      // FIFO-empty gaps plus backpressure.
      gaps = 1'b1;
      build_stream(20, 0);
      run_stream();
      gaps     = 1'b0;
      rand_rdy = 1'b0;

      // ID wrap.
      build_stream(300, 0);
      run_stream();
      if (rec_id.size() > 1840) begin
         chk("t5_id_255", BW'(rec_id[1839]), BW'(255));
         chk("t5_id_wrap", BW'(rec_id[1840]), BW'(0));
      end else begin
         chk("t5_nwords", BW'(rec_id.size()), BW'(2157));
      end

      // Stream truncated after three words of the second vector.
      build_stream(1, 3);
      run_stream();
      chk("trunc_nwords", BW'(rec_data.size()), BW'(11));

      // Reset mid-stream.
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
         i_Vector = {$urandom, $urandom, $urandom, $urandom};
         i_Valid  = 1'b1;
         @(negedge clk);
      end
      #3;
      rstn = 1'b0;
      #1;
      chk("mid_rst_vector", o_Vector, BW'(0));
      chk("mid_rst_valid", BW'(o_Valid), BW'(0));
      chk("mid_rst_vecid", BW'(o_VecID), BW'(0));
      chk("mid_rst_last", BW'(o_Last), BW'(0));
      chk("mid_rst_read", BW'(o_Read), BW'(0));
      @(negedge clk);
      i_Valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      build_stream(1, 0);
      run_stream();
      chk("restart_nwords", BW'(rec_data.size()), BW'(8));
      if (rec_id.size() > 0) chk("restart_id0", BW'(rec_id[0]), BW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
